// File: rtl/ps2_key_decoder_if.sv
// Key-event stream from the PS/2 key decoder to its consumer.
// ev_data = {ext, brk, code[7:0]}; a beat transfers when ev_valid && ev_ready.
interface ps2_key_decoder_if;
    logic [9:0] ev_data;
    logic       ev_valid;
    logic       ev_ready;

    modport master (output ev_data, output ev_valid, input ev_ready);
    modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code parser: turns prefix sequences into make/break events,
// tracks held keys, filters typematic repeats and queues events in a small FIFO.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter bit FILTER_REPEAT  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              keycode,
    input  logic                     key_valid,
    ps2_key_decoder_if.master        ev,
    input  logic [8:0]               query_code,
    output logic                     query_held,
    output logic                     overflow,
    output logic                     timeout
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_E0,
        S_F0,
        S_E0F0,
        S_SKIP
    } state_t;

    state_t          state, state_next;
    logic [2:0]      skip_cnt, skip_next;
    logic [TW-1:0]   tmo_cnt, tmo_next;
    logic            tmo_fire;
    logic            emit;
    logic            emit_pause;
    logic [9:0]      emit_ev;
    logic [7:0]      b;

    logic [511:0]    held;
    logic [8:0]      emit_key;
    logic            emit_make;
    logic            suppress;
    logic            push;

    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full;
    logic            pop;
    logic            do_push;

    logic            unused_prev;

    assign b           = keycode[7:0];
    assign unused_prev = ^keycode[15:8];

    // ------------------------------------------------------------------
    // Parser state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            skip_cnt <= '0;
            tmo_cnt  <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
            tmo_cnt  <= tmo_next;
            timeout  <= tmo_fire;
        end
    end

    // ------------------------------------------------------------------
    // Parser next-state and event generation
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next = state;
        skip_next  = skip_cnt;
        tmo_next   = tmo_cnt;
        tmo_fire   = 1'b0;
        emit       = 1'b0;
        emit_pause = 1'b0;
        emit_ev    = '0;

        if (key_valid) begin
            tmo_next = '0;
            case (state)
                S_IDLE: begin
                    if (b == 8'hE0) begin
                        state_next = S_E0;
                    end else if (b == 8'hF0) begin
                        state_next = S_F0;
                    end else if (b == 8'hE1) begin
                        state_next = S_SKIP;
                        skip_next  = 3'd7;
                    end else if (!(b inside {8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
                        emit    = 1'b1;
                        emit_ev = {2'b00, b};
                    end
                end
                S_E0: begin
                    if (b == 8'hF0) begin
                        state_next = S_E0F0;
                    end else if (b != 8'hE0) begin
                        emit       = 1'b1;
                        emit_ev    = {2'b10, b};
                        state_next = S_IDLE;
                    end
                end
                S_F0: begin
                    if (b != 8'hF0) begin
                        emit       = 1'b1;
                        emit_ev    = {2'b01, b};
                        state_next = S_IDLE;
                    end
                end
                S_E0F0: begin
                    emit       = 1'b1;
                    emit_ev    = {2'b11, b};
                    state_next = S_IDLE;
                end
                S_SKIP: begin
                    // Pause sends seven more bytes after E1; the last one completes the key.
                    skip_next = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        emit       = 1'b1;
                        emit_pause = 1'b1;
                        emit_ev    = {2'b10, 8'h77};
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end else if (state != S_IDLE) begin
            if (tmo_cnt == TMO_LAST) begin
                state_next = S_IDLE;
                tmo_next   = '0;
                tmo_fire   = 1'b1;
            end else begin
                tmo_next = tmo_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Held-key table and repeat filter
    // ------------------------------------------------------------------
    assign emit_key  = {emit_ev[9], emit_ev[7:0]};
    assign emit_make = !emit_ev[8];
    assign suppress  = FILTER_REPEAT && emit_make && held[emit_key];
    assign push      = emit && !suppress;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= '0;
        end else if (emit && !emit_pause) begin
            held[emit_key] <= emit_make;
        end
    end

    assign query_held = held[query_code];

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    assign full    = (count == FIFO_FULL);
    assign pop     = ev.ev_valid && ev.ev_ready;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the entries are reset (only a few words) so the head reads zero out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= emit_ev;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow <= push && full && !pop;
        end
    end

    assign ev.ev_valid = (count != '0);
    assign ev.ev_data  = mem[rd_ptr];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomised scoreboard bench for ps2_key_decoder: a prefix-flag model predicts
// events, held keys, overflow and timeout pulses; a monitor compares every cycle.
module tb_ps2_key_decoder;

    localparam int FIFO_DEPTH     = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keycode = '0;
    logic        key_valid = 1'b0;
    logic [8:0]  query_code = '0;
    logic        query_held;
    logic        overflow;
    logic        timeout;

    ps2_key_decoder_if evif ();

    ps2_key_decoder #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FILTER_REPEAT  (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .keycode    (keycode),
        .key_valid  (key_valid),
        .ev         (evif),
        .query_code (query_code),
        .query_held (query_held),
        .overflow   (overflow),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pending-prefix flags, held set, FIFO occupancy
    // ------------------------------------------------------------------
    bit         pfx_ext, pfx_brk;
    int         pause_left, idle_cnt, m_count;
    bit         held_m [512];
    bit         exp_ovf, exp_tmo;
    bit         pop_m;
    logic [7:0] mb;
    logic [9:0] exp_q [$];

    task automatic model_clear();
        pfx_ext = 0; pfx_brk = 0; pause_left = 0; idle_cnt = 0; m_count = 0;
        exp_ovf = 0; exp_tmo = 0;
        exp_q.delete();
        for (int i = 0; i < 512; i++) held_m[i] = 0;
    endtask

    task automatic model_event(input bit ext, input bit brk, input logic [7:0] code,
                               input bit is_pause, input bit popping);
        int idx;
        idx = {ext, code};
        if (!brk && held_m[idx]) return;
        if (!is_pause) held_m[idx] = !brk;
        if (m_count == FIFO_DEPTH && !popping) begin
            exp_ovf = 1;
        end else begin
            exp_q.push_back({ext, brk, code});
            m_count++;
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_clear();
            end else begin
                exp_ovf = 0;
                exp_tmo = 0;
                pop_m   = (m_count > 0) && evif.ev_ready;
                if (key_valid) begin
                    mb = keycode[7:0];
                    idle_cnt = 0;
                    if (pause_left > 0) begin
                        pause_left--;
                        if (pause_left == 0) model_event(1, 0, 8'h77, 1, pop_m);
                    end else if (mb == 8'hE0 && !pfx_brk) begin
                        pfx_ext = 1;
                    end else if (mb == 8'hF0 && !(pfx_ext && pfx_brk)) begin
                        pfx_brk = 1;
                    end else if (mb == 8'hE1 && !pfx_ext && !pfx_brk) begin
                        pause_left = 7;
                    end else if (!pfx_ext && !pfx_brk &&
                                 mb inside {8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
                        // acknowledge / BAT / error bytes carry no key
                    end else begin
                        model_event(pfx_ext, pfx_brk, mb, 0, pop_m);
                        pfx_ext = 0;
                        pfx_brk = 0;
                    end
                end else if (pfx_ext || pfx_brk || pause_left > 0) begin
                    idle_cnt++;
                    if (idle_cnt == TIMEOUT_CYCLES) begin
                        pfx_ext = 0; pfx_brk = 0; pause_left = 0; idle_cnt = 0;
                        exp_tmo = 1;
                    end
                end
                if (pop_m) m_count--;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares DUT outputs against the model every cycle
    // ------------------------------------------------------------------
    int ev_popped = 0;
    int ovf_seen  = 0;
    int tmo_seen  = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("ev_valid", evif.ev_valid, exp_q.size() != 0);
                if (evif.ev_valid && exp_q.size() != 0) check("ev_data", evif.ev_data, exp_q[0]);
                if (exp_q.size() != 0 && evif.ev_ready) void'(exp_q.pop_front());
                if (evif.ev_valid && evif.ev_ready) ev_popped++;
                check("overflow", overflow, exp_ovf);
                check("timeout", timeout, exp_tmo);
                check("query_held", query_held, held_m[query_code]);
                if (overflow) ovf_seen++;
                if (timeout) tmo_seen++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int         ready_mode = 1;     // 0: hold off, 1: always ready, 2: random
    logic [7:0] keys [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h75, 8'h77, 8'h14, 8'h29};

    task automatic step();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       evif.ev_ready = 1'b0;
            1:       evif.ev_ready = 1'b1;
            default: evif.ev_ready = ($urandom_range(0, 3) != 0);
        endcase
        query_code = {1'($urandom_range(0, 1)), keys[$urandom_range(0, 7)]};
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        keycode   = {keycode[7:0], b};
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic probe(input logic [8:0] code, input logic exp, input string name);
        query_code = code;
        #1;
        check(name, query_held, exp);
    endtask

    task automatic do_reset();
        key_valid = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        ready_mode = 1;
        while (m_count != 0 && n < 200) begin
            step();
            n++;
        end
        step();
        check("drain_ev_valid", evif.ev_valid, 1'b0);
    endtask

    int base;

    initial begin
        evif.ev_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ev_valid", evif.ev_valid, 1'b0);
        check("rst_ev_data", evif.ev_data, 10'h000);
        check("rst_overflow", overflow, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_query_held", query_held, 1'b0);
        rst_n = 1'b1;
        step();

        // make / break of a plain key
        base = ev_popped;
        send(8'h1C, 1);
        probe(9'h01C, 1'b1, "held_A_make");
        send(8'hF0, 1);
        send(8'h1C, 1);
        probe(9'h01C, 1'b0, "held_A_break");
        drain();
        check("count_A", ev_popped - base, 2);

        // extended make / break
        base = ev_popped;
        send(8'hE0, 0);
        send(8'h75, 1);
        probe(9'h175, 1'b1, "held_ext_make");
        send(8'hE0, 0);
        send(8'hF0, 0);
        send(8'h75, 1);
        probe(9'h175, 1'b0, "held_ext_break");
        drain();
        check("count_ext", ev_popped - base, 2);

        // typematic repeats are dropped
        base = ev_popped;
        send(8'h29, 1); send(8'h29, 1); send(8'h29, 1);
        send(8'hF0, 0); send(8'h29, 1);
        drain();
        check("count_repeat", ev_popped - base, 2);

        // pause sequence, then a normal make
        base = ev_popped;
        foreach (keys[i]) begin end
        send(8'hE1, 0); send(8'h14, 0); send(8'h77, 0); send(8'hE1, 0);
        send(8'hF0, 0); send(8'h14, 0); send(8'hF0, 0); send(8'h77, 1);
        probe(9'h177, 1'b0, "held_pause");
        send(8'h1C, 1);
        drain();
        check("count_pause", ev_popped - base, 2);

        // reset in the middle of a prefix
        send(8'hE0, 0);
        do_reset();
        base = ev_popped;
        send(8'h75, 1);
        drain();
        check("count_mid_reset", ev_popped - base, 1);

        // FIFO overflow with the consumer stalled
        do_reset();
        ready_mode = 0;
        ovf_seen = 0;
        base = ev_popped;
        send(8'h1C, 0); send(8'h1B, 0); send(8'h23, 0);
        send(8'h2B, 0); send(8'h75, 0); send(8'h14, 3);
        check("ovf_pulses", ovf_seen, 2);
        check("full_ev_valid", evif.ev_valid, 1'b1);
        drain();
        check("count_ovf", ev_popped - base, 4);

        // prefix timeout, then the boundary one cycle short of it
        do_reset();
        tmo_seen = 0;
        base = ev_popped;
        send(8'hF0, TIMEOUT_CYCLES);
        send(8'h1C, 1);
        check("tmo_pulses", tmo_seen, 1);
        probe(9'h01C, 1'b1, "held_after_tmo");
        send(8'hF0, TIMEOUT_CYCLES - 1);
        send(8'h1C, 1);
        check("tmo_no_pulse", tmo_seen, 1);
        probe(9'h01C, 1'b0, "held_before_tmo");
        drain();
        check("count_tmo", ev_popped - base, 2);

        // randomised traffic
        ready_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            int r, g;
            logic [7:0] bb;
            r = $urandom_range(0, 99);
            if (r < 12)      bb = 8'hE0;
            else if (r < 24) bb = 8'hF0;
            else if (r < 28) bb = 8'hE1;
            else if (r < 34) bb = 8'hFA;
            else if (r < 36) bb = 8'hAA;
            else             bb = keys[$urandom_range(0, 7)];
            r = $urandom_range(0, 99);
            if (r < 70)      g = $urandom_range(0, 2);
            else if (r < 96) g = $urandom_range(3, 6);
            else             g = TIMEOUT_CYCLES + 1;
            send(bb, g);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
